significand_divider: RTL and testbench
======================================

# significand_divider

Sequential radix-2 restoring divider for normalized floating-point significands. It is the division counterpart of the iterative Booth significand multiplier in the double-precision datapath. It takes two W-bit significands (hidden bit included) and produces a W+2-bit truncated quotient plus a sticky bit, from which the downstream normalize/round stage forms the IEEE-754 result. It retires one quotient bit per clock and uses a start/busy/done handshake.

## Interface
- W, default 53, significand width including the hidden bit.
- N, default W+2 (55), number of quotient bits (W plus guard and round). Also the iteration count.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  request; sampled only when busy=0.
- a  input  W  dividend significand; sampled on an accepted start.
- b  input  W  divisor significand; sampled on an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; quotient, sticky and dz are valid from this cycle.
- quotient  output  N  floor(a*2^(N-1)/b).
- sticky  output  1  1 when the final remainder is nonzero.
- dz  output  1  divide-by-zero flag (b==0).

## Operation
- States: IDLE, RUN.
- Internal registers:
  - rem, W+1 bits.
  - div, W bits.
  - q shift register, N bits.
  - count, ceil(log2(N)) bits.
- IDLE with start=1 and b!=0: rem<={1'b0,a}, div<=b, q<=0, count<=0, busy<=1, dz<=0. Go to RUN.
- IDLE with start=1 and b==0: no iteration. Next edge: quotient<=all ones, sticky<=1, dz<=1, done<=1. Stay in IDLE.
- RUN, each edge:
  - Compute diff=rem-{1'b0,div} at W+2 bits.
  - If diff is non-negative: bit=1 and r=diff[W:0]. Otherwise bit=0 and r=rem.
  - q<={q[N-2:0],bit}.
  - rem<={r[W-1:0],1'b0}.
  - count<=count+1.
- RUN, edge with count==N-1: the above happens, then:
  - quotient<={q[N-2:0],bit}.
  - sticky<=(r!=0).
  - done<=1, busy<=0.
  - Go to IDLE.
- Arithmetic range: r<b always holds after subtraction, so rem<2b<2^(W+1) after the shift; W+1 bits never overflow.
- Input range requirement: a<2b. Normalized inputs (a[W-1]=b[W-1]=1) satisfy this and give quotient[N-1:N-2] != 2'b00.
  - If a>=2b: quotient and sticky are unspecified, but the handshake still completes on the normal schedule.
- Output holding: quotient, sticky and dz hold their values until the next done. They are not cleared by a new start.
- done is 0 in every cycle except the completion cycle.

## Timing
- Reset values: busy=0, done=0, quotient=0, sticky=0, dz=0, state=IDLE, count=0, rem=0, q=0.
- Latency, normal case:
  - Start accepted at edge E0.
  - busy=1 from after E0.
  - Iterations run on edges E1..EN.
  - done=1 and results valid after EN, so start-to-done is N cycles (55).
  - Throughput is one operation per N cycles.
- Latency, dz case: done=1 after E1 (1 cycle). busy stays 0 throughout.
- start while busy=1: ignored. a and b are not resampled.
- start in the done cycle: accepted, because the state is IDLE. A back-to-back operation begins with no bubble; done drops on the next edge.
- reset mid-operation: at the next edge, everything returns to reset values. No done is produced for the aborted operation.
- reset and start in the same cycle: reset wins; start is ignored.
- a and b may change freely after the accepting edge.

## Test plan
- a=b=0x10000000000000 (1.0/1.0), start for one cycle -> done exactly 55 cycles later; quotient=0x40000000000000, sticky=0, dz=0.
- a=0x1FFFFFFFFFFFFF, b=0x10000000000000 -> quotient=0x7FFFFFFFFFFFFC, sticky=0.
- a=0x10000000000000, b=0x1FFFFFFFFFFFFF -> quotient=0x20000000000001, sticky=1.
- a=0x18000000000000 (1.5), b=0x10000000000000 -> quotient=0x60000000000000, sticky=0.
- b=0 with any a -> done 1 cycle after start; busy stays 0; quotient=0x7FFFFFFFFFFFFF, sticky=1, dz=1.
- Handshake and reset cases:
  - Start issued with new a/b while busy -> ignored; the original result is still produced.
  - start held high through done -> a second operation starts with no bubble.
  - reset asserted at iteration 20 -> busy=0, done never pulses, outputs=0.

Source files
------------

// File: rtl/significand_divider_if.sv
// Handshake and data bundle for the radix-2 significand divider.
// The requester (master) drives start/a/b; the divider (slave) returns
// busy/done and the registered quotient, sticky and divide-by-zero flags.
interface significand_divider_if #(
  parameter int W = 53,
  parameter int N = W + 2
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic         sticky;
  logic         dz;

  modport master (
    output start, a, b,
    input  busy, done, quotient, sticky, dz
  );

  modport slave (
    input  start, a, b,
    output busy, done, quotient, sticky, dz
  );
endinterface

// File: rtl/significand_divider.sv
// Sequential radix-2 restoring divider for normalized significands.
// One quotient bit retires per clock; N iterations produce
// floor(a*2^(N-1)/b) plus a sticky bit for the final remainder.
// A zero divisor skips iteration and reports all-ones/sticky/dz one edge
// after the request is sampled, without ever raising busy.
module significand_divider #(
  parameter int W = 53,
  parameter int N = W + 2
) (
  input  logic                 clk,
  input  logic                 reset,
  significand_divider_if.slave bus
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Architectural state
  state_t        state_r;
  logic [W:0]    rem_r;
  logic [W-1:0]  div_r;
  logic [N-1:0]  q_r;
  logic [CW-1:0] count_r;
  logic          busy_r;
  logic          done_r;
  logic [N-1:0]  quotient_r;
  logic          sticky_r;
  logic          dz_r;
  // Set on the edge that samples a zero-divisor request; the flags are
  // published on the following edge so the dz case takes one cycle.
  logic          dz_pend_r;

  // Next-state values
  state_t        state_s;
  logic [W:0]    rem_s;
  logic [W-1:0]  div_s;
  logic [N-1:0]  q_s;
  logic [CW-1:0] count_s;
  logic          busy_s;
  logic          done_s;
  logic [N-1:0]  quotient_s;
  logic          sticky_s;
  logic          dz_s;
  logic          dz_pend_s;

  // Iteration datapath
  logic [W+1:0]  diff_s;
  logic          bit_s;
  logic [W:0]    r_s;
  logic [N-1:0]  q_shift_s;

  // Trial subtraction: a clear sign bit means the divisor fits and the
  // remainder is replaced by the difference; otherwise it is restored.
  always_comb begin
    diff_s    = {1'b0, rem_r} - {2'b00, div_r};
    bit_s     = ~diff_s[W+1];
    if (bit_s) begin
      r_s = diff_s[W:0];
    end else begin
      r_s = rem_r;
    end
    q_shift_s = (q_r << 1) | {{(N-1){1'b0}}, bit_s};
  end

  // Next-state and output logic for the IDLE/RUN controller.
  always_comb begin
    state_s    = state_r;
    rem_s      = rem_r;
    div_s      = div_r;
    q_s        = q_r;
    count_s    = count_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    quotient_s = quotient_r;
    sticky_s   = sticky_r;
    dz_s       = dz_r;
    dz_pend_s  = 1'b0;

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if (bus.b != {W{1'b0}}) begin
            rem_s   = {1'b0, bus.a};
            div_s   = bus.b;
            q_s     = {N{1'b0}};
            count_s = {CW{1'b0}};
            busy_s  = 1'b1;
            dz_s    = 1'b0;
            state_s = RUN;
          end else begin
            dz_pend_s = 1'b1;
            state_s   = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end

      RUN: begin
        q_s     = q_shift_s;
        rem_s   = {r_s[W-1:0], 1'b0};
        count_s = count_r + {{(CW-1){1'b0}}, 1'b1};
        if (count_r == LAST_COUNT) begin
          quotient_s = q_shift_s;
          sticky_s   = (r_s != {(W+1){1'b0}});
          done_s     = 1'b1;
          busy_s     = 1'b0;
          state_s    = IDLE;
        end else begin
          state_s = RUN;
        end
      end

      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase

    // A pending zero-divisor result completes here; it owns the result
    // flags on this edge even if a new request is accepted alongside it.
    if (dz_pend_r) begin
      quotient_s = {N{1'b1}};
      sticky_s   = 1'b1;
      dz_s       = 1'b1;
      done_s     = 1'b1;
    end else begin
      dz_s = dz_s;
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      rem_r      <= {(W+1){1'b0}};
      div_r      <= {W{1'b0}};
      q_r        <= {N{1'b0}};
      count_r    <= {CW{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      quotient_r <= {N{1'b0}};
      sticky_r   <= 1'b0;
      dz_r       <= 1'b0;
      dz_pend_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      rem_r      <= rem_s;
      div_r      <= div_s;
      q_r        <= q_s;
      count_r    <= count_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      quotient_r <= quotient_s;
      sticky_r   <= sticky_s;
      dz_r       <= dz_s;
      dz_pend_r  <= dz_pend_s;
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.quotient = quotient_r;
  assign bus.sticky   = sticky_r;
  assign bus.dz       = dz_r;

endmodule

// File: tb/tb_significand_divider.sv
// Scoreboard bench for significand_divider: the driver pushes the result a
// plain-arithmetic reference predicts (value and completion cycle), and an
// independent monitor pops and compares whenever done is seen.
module tb_significand_divider;

  localparam int W = 53;
  localparam int N = W + 2;

  typedef struct {
    logic [N-1:0] q;
    logic         s;
    logic         d;
    int           cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];

  significand_divider_if #(.W(W), .N(N)) bus ();

  significand_divider #(.W(W), .N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used for latency expectations.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: quotient and remainder straight from wide integer division.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int done_cyc);
    exp_t e;
    logic [127:0] num;
    num = 128'(a) << (N - 1);
    if (b == {W{1'b0}}) begin
      e.q = {N{1'b1}};
      e.s = 1'b1;
      e.d = 1'b1;
    end else begin
      e.q = N'(num / 128'(b));
      e.s = ((num % 128'(b)) != 128'd0);
      e.d = 1'b0;
    end
    e.cyc = done_cyc;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (bus.done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 with no outstanding operation (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("quotient", 128'(bus.quotient), 128'(e.q));
        check("sticky", 128'(bus.sticky), 128'(e.s));
        check("dz", 128'(bus.dz), 128'(e.d));
        check("done_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  // Issue one request; caller is positioned just after a rising edge.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input bit hold);
    int guard;
    guard = 0;
    while (bus.busy && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (bus.busy) begin
      check("idle_timeout", 128'(bus.busy), 128'd0);
    end
    bus.a     = ta;
    bus.b     = tb_v;
    bus.start = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(model(ta, tb_v, (tb_v == {W{1'b0}}) ? cyc + 1 : cyc + N));
    check("busy_after_accept", 128'(bus.busy), 128'(tb_v != {W{1'b0}}));
    if (!hold) bus.start = 1'b0;
    if (tb_v == {W{1'b0}}) begin
      @(posedge clk); #1;
      check("dz_busy_low", 128'(bus.busy), 128'd0);
    end
  endtask

  task automatic wait_drain(input int limit);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < limit) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_outstanding", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 128'(bus.busy), 128'd0);
    check({tag, "_done"}, 128'(bus.done), 128'd0);
    check({tag, "_quotient"}, 128'(bus.quotient), 128'd0);
    check({tag, "_sticky"}, 128'(bus.sticky), 128'd0);
    check({tag, "_dz"}, 128'(bus.dz), 128'd0);
  endtask

  initial begin
    logic [63:0] r1;
    logic [63:0] r2;
    logic [63:0] two_b;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int mode;

    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = {W{1'b0}};
    bus.b     = {W{1'b0}};
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // Directed values from the datapath's reference cases.
    start_op(53'h10000000000000, 53'h10000000000000, 1'b0);
    start_op(53'h1FFFFFFFFFFFFF, 53'h10000000000000, 1'b0);
    start_op(53'h10000000000000, 53'h1FFFFFFFFFFFFF, 1'b0);
    start_op(53'h18000000000000, 53'h10000000000000, 1'b0);
    start_op(53'h00000000001234, 53'h00000000000000, 1'b0);
    wait_drain(200);

    // New start with different operands while busy must be ignored.
    start_op(53'h15555555555555, 53'h1AAAAAAAAAAAAA, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    bus.a     = 53'h1FFFFFFFFFFFFF;
    bus.b     = 53'h10000000000001;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = {W{1'b0}};
    bus.b     = {W{1'b0}};
    wait_drain(200);

    // start held through done: the second operation follows with no bubble.
    start_op(53'h1C000000000000, 53'h14000000000000, 1'b1);
    start_op(53'h13333333333333, 53'h1EEEEEEEEEEEEE, 1'b0);
    wait_drain(300);

    // Reset at iteration 20 aborts without a done pulse.
    start_op(53'h1ABCDEF0123456, 53'h1123456789ABCD, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    check_reset_outputs("abort");
    reset = 1'b0;
    repeat (N + 5) @(posedge clk);
    #1;
    check("abort_no_busy", 128'(bus.busy), 128'd0);

    // Reset and start in the same cycle: reset wins.
    reset     = 1'b1;
    bus.a     = 53'h10000000000000;
    bus.b     = 53'h10000000000000;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    reset     = 1'b0;
    check("reset_start_busy", 128'(bus.busy), 128'd0);
    @(posedge clk); #1;
    check("reset_start_busy_later", 128'(bus.busy), 128'd0);

    // Randomized operands: mostly normalized, some arbitrary with a<2b, some b=0.
    for (int i = 0; i < 24; i++) begin
      r1   = {$urandom, $urandom};
      r2   = {$urandom, $urandom};
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        ra = r1[W-1:0];
        rb = {W{1'b0}};
      end else if (mode <= 2) begin
        rb = r2[W-1:0];
        if (rb == {W{1'b0}}) rb = {{(W-1){1'b0}}, 1'b1};
        two_b = {11'd0, rb} << 1;
        ra = W'(r1 % two_b);
      end else begin
        ra = {1'b1, r1[W-2:0]};
        rb = {1'b1, r2[W-2:0]};
      end
      start_op(ra, rb, 1'b0);
    end
    wait_drain(300);
    repeat (3) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
